imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the core's fetch interface.
- Accepts fetch requests (PC) over a valid/ready channel and returns the 32-bit instruction word after a configurable latency.
- Backed by a word array that a testbench/loader fills through a write port.
- Sits between the core's fetch unit and the simulation memory model. Synthesisable, single outstanding request.

---
 rtl/npc_mem_pkg.sv | 19 +
 rtl/imem_array.sv | 49 ++++
 rtl/imem_responder.sv | 109 ++++++++++
 tb/tb_imem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
// rtl/npc_mem_pkg.sv - shared constants and types for the simulation memory models
package npc_mem_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] MEM_BASE     = RESET_VECTOR;
    localparam int          XLEN         = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } mem_rsp_t;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word array with registered read port, write port and per-word valid bits
module imem_array
    import npc_mem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_idx,
    input  logic          rd_err,
    output mem_rsp_t      rd_rsp
);

    logic [31:0]      mem [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Reads sample the pre-write contents, so a same-edge write returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_rsp <= '0;
        end else if (rd_en) begin
            if (rd_err || !valid_q[rd_idx]) begin
                rd_rsp <= '{data: 32'h0, err: rd_err};
            end else begin
                rd_rsp <= '{data: mem[rd_idx], err: 1'b0};
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction fetch responder with configurable latency
module imem_responder
    import npc_mem_pkg::*;
#(
    parameter logic [31:0] BASE    = MEM_BASE,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int          IW        = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    fsm_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        capture;
    logic [31:0] fetch_addr;
    logic [29:0] fetch_woff, ld_woff;
    logic        fetch_err, ld_err, ld_wr;
    mem_rsp_t    rsp_q;

    // BASE is word aligned, so word offsets can be formed without the low bits.
    assign fetch_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign fetch_woff = fetch_addr[31:2] - BASE[31:2];
    assign fetch_err  = (fetch_addr[1:0] != 2'b00) || (fetch_woff >= DEPTH_W);

    assign ld_woff = ld_addr[31:2] - BASE[31:2];
    assign ld_err  = (ld_addr[1:0] != 2'b00) || (ld_woff >= DEPTH_W);
    assign ld_wr   = ld_en && !ld_err;

    assign req_ready = rst && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_q.data;
    assign rsp_err   = rsp_q.err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (LATENCY == 0) begin
                        capture = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ld_wr),
        .wr_idx  (ld_woff[IW-1:0]),
        .wr_data (ld_data),
        .rd_en   (capture),
        .rd_idx  (fetch_woff[IW-1:0]),
        .rd_err  (fetch_err),
        .rd_rsp  (rsp_q)
    );

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed vector bench for imem_responder (LATENCY 1 and 0 builds)
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, rsp_data;
    logic        req_valid_z, req_ready_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
    logic [31:0] req_addr_z, rsp_data_z;
    logic        ld_en;
    logic [31:0] ld_addr, ld_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_d;
    logic        got_e;
    int          got_lat;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(4096), .LATENCY(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    imem_responder #(.DEPTH(4096), .LATENCY(0)) u_dut_z (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid_z),
        .req_ready (req_ready_z),
        .req_addr  (req_addr_z),
        .rsp_valid (rsp_valid_z),
        .rsp_ready (rsp_ready_z),
        .rsp_data  (rsp_data_z),
        .rsp_err   (rsp_err_z),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    // Issues one request on the LATENCY=1 instance and waits (bounded) for rsp_valid.
    task automatic fetch(input logic [31:0] a);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFF0;
        got_lat   = 0;
        while (!rsp_valid && got_lat < 20) begin
            step();
            got_lat++;
        end
        got_d = rsp_data;
        got_e = rsp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{addr: 32'h8000_0000, data: 32'h0010_0093, err: 1'b0};
        vecs[1] = '{addr: 32'h8000_0004, data: 32'h0020_0113, err: 1'b0};
        vecs[2] = '{addr: 32'h8000_0002, data: 32'h0000_0000, err: 1'b1};
        vecs[3] = '{addr: 32'h8000_4000, data: 32'h0000_0000, err: 1'b1};
        vecs[4] = '{addr: 32'h7FFF_FFFC, data: 32'h0000_0000, err: 1'b1};
        vecs[5] = '{addr: 32'h8000_3FFC, data: 32'h1234_5678, err: 1'b0};
        vecs[6] = '{addr: 32'h8000_0010, data: 32'h0000_0000, err: 1'b0};
        vecs[7] = '{addr: 32'h8000_0001, data: 32'h0000_0000, err: 1'b1};
        vecs[8] = '{addr: 32'h0000_0000, data: 32'h0000_0000, err: 1'b1};

        rst         = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        rsp_ready   = 1'b1;
        req_valid_z = 1'b0;
        req_addr_z  = '0;
        rsp_ready_z = 1'b1;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_valid_z", 32'(rsp_valid_z), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        step();

        load(32'h8000_0000, 32'h0010_0093);
        load(32'h8000_0004, 32'h0020_0113);
        load(32'h8000_3FFC, 32'h1234_5678);
        load(32'h8000_0008, 32'h1111_1111);
        load(32'h8000_4000, 32'hBAD0_BAD0);
        load(32'h7FFF_FFFC, 32'hCAFE_F00D);
        load(32'h8000_0011, 32'hFFFF_FFFF);

        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i].addr);
            chk($sformatf("vec%0d_latency", i), 32'(got_lat), 32'd1);
            chk($sformatf("vec%0d_data", i), got_d, vecs[i].data);
            chk($sformatf("vec%0d_err", i), 32'(got_e), 32'(vecs[i].err));
            step();
            chk($sformatf("vec%0d_rsp_done", i), 32'(rsp_valid), 32'd0);
        end

        // Backpressure: response held for 5 cycles while new requests are ignored.
        rsp_ready = 1'b0;
        fetch(32'h8000_0004);
        chk("bp_data", got_d, 32'h0020_0113);
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'h8000_0000;
            step();
            chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_data", k), rsp_data, 32'h0020_0113);
            chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);

        // Loader write on the capture edge of a fetch to the same word.
        req_valid = 1'b1;
        req_addr  = 32'h8000_0008;
        step();
        req_valid = 1'b0;
        ld_en     = 1'b1;
        ld_addr   = 32'h8000_0008;
        ld_data   = 32'hDEAD_BEEF;
        step();
        ld_en = 1'b0;
        chk("coll_valid", 32'(rsp_valid), 32'd1);
        chk("coll_old_data", rsp_data, 32'h1111_1111);
        step();
        fetch(32'h8000_0008);
        chk("coll_new_data", got_d, 32'hDEAD_BEEF);
        step();

        // LATENCY=0 instance: back-to-back requests, one per two cycles.
        chk("z_ready0", 32'(req_ready_z), 32'd1);
        req_valid_z = 1'b1;
        req_addr_z  = 32'h8000_0000;
        step();
        chk("z_rsp0_valid", 32'(rsp_valid_z), 32'd1);
        chk("z_rsp0_data", rsp_data_z, 32'h0010_0093);
        chk("z_rsp0_ready", 32'(req_ready_z), 32'd0);
        req_addr_z = 32'h8000_0004;
        step();
        chk("z_gap_valid", 32'(rsp_valid_z), 32'd0);
        chk("z_gap_ready", 32'(req_ready_z), 32'd1);
        step();
        chk("z_rsp1_valid", 32'(rsp_valid_z), 32'd1);
        chk("z_rsp1_data", rsp_data_z, 32'h0020_0113);
        chk("z_rsp1_err", 32'(rsp_err_z), 32'd0);
        req_valid_z = 1'b0;
        step();
        chk("z_done_valid", 32'(rsp_valid_z), 32'd0);

        // Asynchronous reset while the LATENCY=1 instance is in WAIT.
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        step();
        req_valid = 1'b0;
        chk("abort_in_wait", 32'(rsp_valid), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("abort_quiet%0d", k), 32'(rsp_valid), 32'd0);
            step();
        end
        fetch(32'h8000_0000);
        chk("after_rst_latency", 32'(got_lat), 32'd1);
        chk("after_rst_uninit_data", got_d, 32'd0);
        chk("after_rst_uninit_err", 32'(got_e), 32'd0);
        step();
        load(32'h8000_0000, 32'h0010_0093);
        fetch(32'h8000_0000);
        chk("after_rst_reload", got_d, 32'h0010_0093);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
